// File: rtl/digit_scan_driver.sv
// digit_scan_driver: time-multiplexed scan controller for a 4-digit seven-segment display.
// Produces a one-hot digit selector, the matching active-low anode drive with
// 16-level brightness PWM, and a frame pulse each time the scan wraps.
// Optional anti-ghosting blanking at the start of every slot is compiled in
// when the macro DIGIT_SCAN_BLANK_EN is defined.
module digit_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit_en,
    input  logic [3:0] brightness,
    output logic [3:0] selector,
    output logic [3:0] anode_n,
    output logic       frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned LIM_W = CNT_W + 1;
    localparam int unsigned STEP  = REFRESH_DIV / 16;

    // Reject parameter sets that cannot produce a valid slot layout.
    if (REFRESH_DIV < 16 || (REFRESH_DIV % 16) != 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_params
        $error("digit_scan_driver: invalid REFRESH_DIV/BLANK_CYCLES");
    end

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [3:0]       selector_q, selector_d;
    logic [3:0]       anode_n_q,  anode_n_d;
    logic             frame_tick_q, frame_tick_d;

    logic [1:0]       cur_idx;
    logic [1:0]       next_idx;
    logic             next_found;
    logic             terminal;
    logic [LIM_W-1:0] on_limit;
    logic             on_window;

    // Locate the current digit and the next enabled digit, ascending with wrap.
    always_comb begin
        logic [1:0] cand;
        cur_idx    = 2'd0;
        next_idx   = 2'd0;
        next_found = 1'b0;
        cand       = 2'd0;
        case (selector_q)
            4'b0010: cur_idx = 2'd1;
            4'b0100: cur_idx = 2'd2;
            4'b1000: cur_idx = 2'd3;
            default: cur_idx = 2'd0;
        endcase
        next_idx = cur_idx;
        for (int k = 1; k <= 4; k++) begin
            cand = cur_idx + 2'(k);
            if (!next_found && digit_en[cand]) begin
                next_idx   = cand;
                next_found = 1'b1;
            end
        end
    end

    // Slot counter, selector advance and frame pulse.
    always_comb begin
        slot_cnt_d   = slot_cnt_q;
        selector_d   = selector_q;
        frame_tick_d = 1'b0;
        terminal     = (slot_cnt_q == CNT_W'(REFRESH_DIV - 1));
        if (!enable) begin
            slot_cnt_d = '0;
        end else if (terminal) begin
            slot_cnt_d = '0;
            // With an empty mask there is nothing to advance to: hold the digit.
            if (next_found) begin
                selector_d   = 4'b0001 << next_idx;
                frame_tick_d = (next_idx <= cur_idx);
            end
        end else begin
            slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end
    end

    // Anode drive evaluated against the values the registers take this edge.
    always_comb begin
        on_limit = LIM_W'({1'b0, brightness} + 5'd1) * LIM_W'(STEP);
`ifdef DIGIT_SCAN_BLANK_EN
        on_window = ({1'b0, slot_cnt_d} < on_limit) && (slot_cnt_d >= CNT_W'(BLANK_CYCLES));
`else
        on_window = ({1'b0, slot_cnt_d} < on_limit);
`endif
        anode_n_d = ~(selector_d & digit_en & {4{enable & on_window}});
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q   <= '0;
            selector_q   <= 4'b0001;
            anode_n_q    <= 4'b1111;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            selector_q   <= selector_d;
            anode_n_q    <= anode_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign selector   = selector_q;
    assign anode_n    = anode_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/digit_scan_driver.md
# digit_scan_driver

Time-multiplexed scan controller for the 4-digit seven-segment display. Generates the one-hot digit `selector` consumed by the digit multiplexor and the matching active-low anode drive, so only one digit is lit at a time. Supports a per-digit enable mask, 16-level brightness PWM and optional anti-ghosting blanking. Sits between the top-level clock domain and the display datapath (digit mux → segment decoder → pins).

## Interface
- `REFRESH_DIV`, 100000: clock cycles per digit slot; must be ≥ 16 and a multiple of 16.
- `BLANK_CYCLES`, 1000: dark cycles at the start of each slot; must be < `REFRESH_DIV`. Used only with `DIGIT_SCAN_BLANK_EN`.
- `clk`  in  1  system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  scan enable; low = display dark, scan frozen.
- `digit_en`  in  4  per-digit mask; bit i = 1 includes digit i in the scan.
- `brightness`  in  4  on-time per slot = (brightness+1)/16 of the slot.
- `selector`  out  4  one-hot digit select to the digit mux (bit0 = seconds units … bit3 = tens of minutes).
- `anode_n`  out  4  active-low anode drive.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps.

## Operation
- Reset values: `selector` = 4'b0001, `anode_n` = 4'b1111, `frame_tick` = 0, slot counter = 0.
- Slot counter `slot_cnt` counts 0..REFRESH_DIV-1 while `enable` = 1, then wraps to 0.
- At terminal count (`slot_cnt` = REFRESH_DIV-1), `selector` advances to the next set bit of `digit_en`, searching ascending from the current index with wrap 3→0. Disabled digits are skipped.
- If `digit_en` = 0: `selector` holds, all anodes off, counter keeps running.
- If only the current digit is enabled, `selector` stays put.
- `frame_tick` = 1 for one cycle on each advance edge whose new index ≤ the old index (wrap), including the single-enabled-digit case.
- On-window: `slot_cnt` < (brightness+1)·(REFRESH_DIV/16). With blanking compiled in, also requires `slot_cnt` ≥ BLANK_CYCLES.
- `anode_n[i]` = 0 iff `selector[i]` & `digit_en[i]` & `enable` & on-window. Otherwise 1.
- `selector` is always exactly one-hot. `anode_n` never has more than one bit low. A low anode bit always matches `selector`.
- `enable` low: counter forced to 0, `selector` held, `anode_n` = 4'b1111, no `frame_tick`. On re-enable, the scan resumes at the held digit from `slot_cnt` = 0.
- If `digit_en` drops the current digit mid-slot, its anode goes off; the advance still occurs at terminal count.
- `brightness` and `digit_en` are sampled every cycle; changes take effect on the next edge.

## Timing
- All outputs are registered and update on the same `clk` rising edge.
- Advance edge: `selector` changes, `frame_tick` pulses and `slot_cnt` returns to 0 together.
- Anode turn-on in a new slot:
  - Same edge as the `selector` change without blanking.
  - Exactly BLANK_CYCLES cycles later with blanking.
- Input-to-anode latency: 1 cycle for `enable`, `digit_en` and `brightness`.
- Asynchronous `reset` forces reset values immediately, regardless of `clk`. Deassertion is synchronous to the design's reset synchronizer.
- Per-digit refresh rate = f_clk / (REFRESH_DIV · N_enabled).

## Configuration
- `DIGIT_SCAN_BLANK_EN` defined:
  - The first BLANK_CYCLES of every slot are dark.
  - `selector` has already switched, so the mux and decoder settle while anodes are off, which eliminates ghosting.
- Not defined:
  - No blanking; the on-window starts at `slot_cnt` = 0.
  - BLANK_CYCLES is ignored.

## Test plan
- Reset and basic scan (REFRESH_DIV=32, `digit_en`=4'hF, `brightness`=15, `enable`=1, no blanking): sequence is 0001→0010→0100→1000→0001, 32 cycles each. `anode_n` = ~`selector`. `frame_tick` pulses once per 128 cycles, on the 1000→0001 edge.
- Mask skip (`digit_en`=4'b0101): `selector` alternates 0001/0100 every 32 cycles; `frame_tick` on each 0100→0001 edge. With `digit_en`=0: `anode_n`=1111 and `selector` frozen.
- Brightness (`brightness`=3, REFRESH_DIV=32): anode low for cycles 0–7 of each slot, high for 8–31.
- Blanking (macro on, BLANK_CYCLES=4, `brightness`=15): anode high for cycles 0–3 after each advance, low for 4–31. `selector` changes at cycle 0.
- Enable and reset mid-slot:
  - `enable` dropped at `slot_cnt`=10: `anode_n`=1111 the next cycle, `selector` held. Re-enable gives a full 32-cycle slot on the same digit.
  - Async `reset` pulsed between clock edges: outputs return to 0001/1111/0 immediately.
- Mid-slot mask drop: clear the current digit's `digit_en` bit at `slot_cnt`=5. Its anode goes high the next cycle, and `selector` advances to the next enabled digit at terminal count.
